// File: rtl/left_shift_rotator_seq_if.sv
// Request/result handshake bundle for the multi-cycle left shift/rotate unit.
// The master side issues requests and consumes results; the slave side is the unit itself.
interface left_shift_rotator_seq_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] In;
  logic             shift;
  logic [AMT_W-1:0] ShAmt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             busy;

  modport master (
    output in_valid, In, shift, ShAmt, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, In, shift, ShAmt, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/left_shift_rotator_seq.sv
// Multi-cycle logical-shift-left / rotate-left unit: moves the operand one bit per cycle,
// with valid/ready on both the request and result sides so the pipeline can stall on it.
module left_shift_rotator_seq #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  left_shift_rotator_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             mode_q,  mode_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic             accept;

  // Ready is gated by reset so nothing can be handed over while the unit is held in reset.
  assign bus.in_ready  = rst_n & (state_q == IDLE);
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out       = data_q;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);

  // NOTE: every signal assigned in this block gets its hold value first, so no path
  // through the case leaves one unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mode_d  = mode_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = bus.In;
          mode_d  = bus.shift;
          count_d = bus.ShAmt;
          state_d = (bus.ShAmt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        data_d  = mode_q ? {data_q[WIDTH-2:0], 1'b0}
                         : {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        count_d = count_q - AMT_W'(1);
        if (count_q == AMT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      mode_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      count_q <= count_d;
    end
  end

endmodule
